// File: rtl/seg_display_driver.sv
`default_nettype none
// ============================================================================
// Module   : seg_display_driver
// Purpose  : Captures a 3-digit BCD value on a strobe and drives three
//            active-low 7-segment displays through registered outputs.
//            Performs leading-zero blanking, shows an 'E' glyph for any
//            non-BCD digit, and flashes the whole display for a timed
//            sequence after each counter-wrap pulse.
// Ports    : Clock       - system clock (rising edge)
//            Reset       - synchronous, active-high reset
//            digit_valid - single-cycle strobe, captures ones/tens/hundreds
//            ones        - BCD units digit
//            tens        - BCD tens digit
//            hundreds    - BCD hundreds digit
//            wrap_pulse  - single-cycle pulse, counter rolled 999 -> 000
//            flashing    - high while the flash sequence is active
//            HEX0        - right-most display, segments a..g (index 0 = a)
//            HEX1        - middle display
//            HEX2        - left-most display
// Options  : SEG_LEADING_ZERO_BLANK_EN - when defined, HEX2 is blanked for a
//            zero hundreds digit and HEX1 for zero hundreds and tens.
//            When undefined all three digits are always decoded.
// Revision : 1.0 - initial release
// ============================================================================
module seg_display_driver #(
    parameter int BLINK_HALF  = 25_000_000, // cycles per dark / lit phase, >= 1
    parameter int BLINK_COUNT = 3,          // dark phases per sequence, 0 = off
    parameter int CNT_W       = 25          // phase counter width, holds BLINK_HALF-1
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic       digit_valid,
    input  logic [3:0] ones,
    input  logic [3:0] tens,
    input  logic [3:0] hundreds,
    input  logic       wrap_pulse,
    output logic       flashing,
    output logic [0:6] HEX0,
    output logic [0:6] HEX1,
    output logic [0:6] HEX2
);

    // Dark-phase counter must hold values 1..BLINK_COUNT.
    localparam int DC_W = (BLINK_COUNT < 2) ? 1 : $clog2(BLINK_COUNT + 1);

    localparam logic [CNT_W-1:0] c_phase_last = CNT_W'(BLINK_HALF - 1);
    localparam logic [DC_W-1:0]  c_dark_last  = DC_W'(BLINK_COUNT);
    localparam logic [DC_W-1:0]  c_dark_one   = DC_W'(1);
    localparam logic [0:6]       c_seg_blank  = 7'b1111111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DARK = 2'd1,
        ST_LIT  = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    logic [3:0]       ones_q, ones_d;
    logic [3:0]       tens_q, tens_d;
    logic [3:0]       hund_q, hund_d;
    state_t           state_q, state_d;
    logic [CNT_W-1:0] phase_q, phase_d;
    logic [DC_W-1:0]  dark_cnt_q, dark_cnt_d;
    logic             flashing_q, flashing_d;
    logic [0:6]       hex0_q, hex0_d;
    logic [0:6]       hex1_q, hex1_d;
    logic [0:6]       hex2_q, hex2_d;

    // Segment pattern, index 0 = segment a, active-low.
    function automatic logic [0:6] seg_decode(input logic [3:0] digit);
        logic [0:6] seg;
        case (digit)
            4'd0:    seg = 7'b0000001;
            4'd1:    seg = 7'b1001111;
            4'd2:    seg = 7'b0010010;
            4'd3:    seg = 7'b0000110;
            4'd4:    seg = 7'b1001100;
            4'd5:    seg = 7'b0100100;
            4'd6:    seg = 7'b0100000;
            4'd7:    seg = 7'b0001111;
            4'd8:    seg = 7'b0000000;
            4'd9:    seg = 7'b0000100;
            default: seg = 7'b0110000; // 'E' for non-BCD input
        endcase
        return seg;
    endfunction

    // ------------------------------------------------------------------
    // Capture stage
    // ------------------------------------------------------------------
    always_comb begin
        ones_d = ones_q;
        tens_d = tens_q;
        hund_d = hund_q;
        if (digit_valid) begin
            ones_d = ones;
            tens_d = tens;
            hund_d = hundreds;
        end
    end

    // ------------------------------------------------------------------
    // Flash sequencer next-state
    // ------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        phase_d    = phase_q;
        dark_cnt_d = dark_cnt_q;
        unique case (state_q)
            ST_IDLE: begin
                if (wrap_pulse && (BLINK_COUNT > 0)) begin
                    state_d    = ST_DARK;
                    phase_d    = '0;
                    dark_cnt_d = c_dark_one;
                end
            end
            ST_DARK: begin
                // A retrigger wins over the phase-end transition.
                if (wrap_pulse) begin
                    state_d    = ST_DARK;
                    phase_d    = '0;
                    dark_cnt_d = c_dark_one;
                end else if (phase_q == c_phase_last) begin
                    phase_d = '0;
                    state_d = (dark_cnt_q == c_dark_last) ? ST_IDLE : ST_LIT;
                end else begin
                    phase_d = phase_q + 1'b1;
                end
            end
            ST_LIT: begin
                if (wrap_pulse) begin
                    state_d    = ST_DARK;
                    phase_d    = '0;
                    dark_cnt_d = c_dark_one;
                end else if (phase_q == c_phase_last) begin
                    state_d    = ST_DARK;
                    phase_d    = '0;
                    dark_cnt_d = dark_cnt_q + c_dark_one;
                end else begin
                    phase_d = phase_q + 1'b1;
                end
            end
            default: begin
                state_d    = ST_IDLE;
                phase_d    = '0;
                dark_cnt_d = '0;
            end
        endcase
        flashing_d = (state_d != ST_IDLE);
    end

    // ------------------------------------------------------------------
    // Decode / output stage: works from the registered digits and state,
    // so a new capture or state change shows one edge later.
    // ------------------------------------------------------------------
    always_comb begin
        hex0_d = seg_decode(ones_q);
        hex1_d = seg_decode(tens_q);
        hex2_d = seg_decode(hund_q);
`ifdef SEG_LEADING_ZERO_BLANK_EN
        if (hund_q == 4'd0) begin
            hex2_d = c_seg_blank;
            if (tens_q == 4'd0) begin
                hex1_d = c_seg_blank;
            end
        end
`else
`endif
        if (state_q == ST_DARK) begin
            hex0_d = c_seg_blank;
            hex1_d = c_seg_blank;
            hex2_d = c_seg_blank;
        end
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge Clock) begin
        if (Reset) begin
            ones_q     <= '0;
            tens_q     <= '0;
            hund_q     <= '0;
            state_q    <= ST_IDLE;
            phase_q    <= '0;
            dark_cnt_q <= '0;
            flashing_q <= 1'b0;
            hex0_q     <= c_seg_blank;
            hex1_q     <= c_seg_blank;
            hex2_q     <= c_seg_blank;
        end else begin
            ones_q     <= ones_d;
            tens_q     <= tens_d;
            hund_q     <= hund_d;
            state_q    <= state_d;
            phase_q    <= phase_d;
            dark_cnt_q <= dark_cnt_d;
            flashing_q <= flashing_d;
            hex0_q     <= hex0_d;
            hex1_q     <= hex1_d;
            hex2_q     <= hex2_d;
        end
    end

    assign flashing = flashing_q;
    assign HEX0     = hex0_q;
    assign HEX1     = hex1_q;
    assign HEX2     = hex2_q;

endmodule
`default_nettype wire

// File: tb/tb_seg_display_driver.sv
`default_nettype none
// ============================================================================
// Module   : tb_seg_display_driver
// Purpose  : Self-checking bench for seg_display_driver. Directed scenarios
//            followed by randomized stimulus, checked every cycle against a
//            timeline-based reference model of the display.
// Revision : 1.0 - initial release
// ============================================================================
module tb_seg_display_driver;

    localparam int BH  = 4;
    localparam int BC  = 2;
    localparam int LEN = (2 * BC - 1) * BH;  // cycles the display flashes

    logic       Clock = 1'b0;
    logic       Reset = 1'b1;
    logic       digit_valid = 1'b0;
    logic [3:0] ones = 4'd0;
    logic [3:0] tens = 4'd0;
    logic [3:0] hundreds = 4'd0;
    logic       wrap_pulse = 1'b0;
    logic       flashing;
    logic [0:6] HEX0;
    logic [0:6] HEX1;
    logic [0:6] HEX2;

    int total = 0;
    int bad   = 0;

    // Reference model state
    logic [3:0] m_o = 4'd0, m_t = 4'd0, m_h = 4'd0;
    bit         m_active = 1'b0;
    bit         m_dark   = 1'b0;
    int         m_start  = 0;
    int         n_edge   = 0;
    logic [0:6] e_hex0 = 7'b1111111, e_hex1 = 7'b1111111, e_hex2 = 7'b1111111;

    seg_display_driver #(
        .BLINK_HALF  (BH),
        .BLINK_COUNT (BC),
        .CNT_W       (3)
    ) dut (
        .Clock       (Clock),
        .Reset       (Reset),
        .digit_valid (digit_valid),
        .ones        (ones),
        .tens        (tens),
        .hundreds    (hundreds),
        .wrap_pulse  (wrap_pulse),
        .flashing    (flashing),
        .HEX0        (HEX0),
        .HEX1        (HEX1),
        .HEX2        (HEX2)
    );

    always #5 Clock = ~Clock;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%07b expected=%07b (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [0:6] ref_seg(input logic [3:0] d);
        case (d)
            4'd0:    return 7'b0000001;
            4'd1:    return 7'b1001111;
            4'd2:    return 7'b0010010;
            4'd3:    return 7'b0000110;
            4'd4:    return 7'b1001100;
            4'd5:    return 7'b0100100;
            4'd6:    return 7'b0100000;
            4'd7:    return 7'b0001111;
            4'd8:    return 7'b0000000;
            4'd9:    return 7'b0000100;
            default: return 7'b0110000;
        endcase
    endfunction

    // One clock cycle: apply inputs, advance the model, compare outputs.
    task automatic step(input logic rst, input logic dv, input logic [3:0] o,
                        input logic [3:0] t, input logic [3:0] h, input logic w);
        int el;
        Reset = rst; digit_valid = dv; ones = o; tens = t; hundreds = h; wrap_pulse = w;
        @(posedge Clock);
        if (rst) begin
            m_o = 0; m_t = 0; m_h = 0;
            m_active = 0; m_dark = 0;
            e_hex0 = 7'b1111111; e_hex1 = 7'b1111111; e_hex2 = 7'b1111111;
        end else begin
            // Display reflects digits and darkness as they stood before this edge.
            if (m_dark) begin
                e_hex0 = 7'b1111111; e_hex1 = 7'b1111111; e_hex2 = 7'b1111111;
            end else begin
                e_hex0 = ref_seg(m_o);
                e_hex1 = ref_seg(m_t);
                e_hex2 = ref_seg(m_h);
`ifdef SEG_LEADING_ZERO_BLANK_EN
                if (m_h == 0) e_hex2 = 7'b1111111;
                if (m_h == 0 && m_t == 0) e_hex1 = 7'b1111111;
`endif
            end
            if (dv) begin m_o = o; m_t = t; m_h = h; end
            if (w && BC > 0) begin
                m_active = 1; m_start = n_edge;
            end
            el = n_edge - m_start;
            if (m_active && el >= LEN) m_active = 0;
            // Even-numbered phases of the flash timeline are dark.
            m_dark = m_active && (((el / BH) % 2) == 0);
        end
        n_edge++;
        #1;
        check_val("flashing", flashing, m_active);
        check_val("hex0", HEX0, e_hex0);
        check_val("hex1", HEX1, e_hex1);
        check_val("hex2", HEX2, e_hex2);
    endtask

    task automatic idle(input int cycles);
        for (int i = 0; i < cycles; i++) step(0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        // 1. Reset then idle
        step(1, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0);
        check_val("rst_hex0", HEX0, 7'b1111111);
        check_val("rst_flash", flashing, 1'b0);
        idle(2);
        check_val("t1_hex0", HEX0, 7'b0000001);
`ifdef SEG_LEADING_ZERO_BLANK_EN
        check_val("t1_hex1", HEX1, 7'b1111111);
        check_val("t1_hex2", HEX2, 7'b1111111);
`endif

        // 2. 049
        step(0, 1, 4'd9, 4'd4, 4'd0, 0);
        idle(1);
        check_val("t2_hex0", HEX0, 7'b0000100);
        check_val("t2_hex1", HEX1, 7'b1001100);
`ifdef SEG_LEADING_ZERO_BLANK_EN
        check_val("t2_hex2", HEX2, 7'b1111111);
`endif

        // 3. 100, and 007
        step(0, 1, 4'd0, 4'd0, 4'd1, 0);
        idle(1);
        check_val("t3_hex2", HEX2, 7'b1001111);
        check_val("t3_hex1", HEX1, 7'b0000001);
        check_val("t3_hex0", HEX0, 7'b0000001);
        step(0, 1, 4'd7, 4'd0, 4'd0, 0);
        idle(1);
        check_val("t3b_hex0", HEX0, 7'b0001111);
`ifndef SEG_LEADING_ZERO_BLANK_EN
        check_val("t3b_hex1", HEX1, 7'b0000001);
        check_val("t3b_hex2", HEX2, 7'b0000001);
`endif

        // 4. Invalid ones digit
        step(0, 1, 4'hC, 4'd3, 4'd0, 0);
        idle(1);
        check_val("t4_hex0", HEX0, 7'b0110000);

        // 5. Flash sequence, then retrigger during LIT
        step(0, 0, 0, 0, 0, 1);
        check_val("t5_flash", flashing, 1'b1);
        idle(LEN + 2);
        check_val("t5_done", flashing, 1'b0);
        step(0, 0, 0, 0, 0, 1);
        idle(5);
        step(0, 0, 0, 0, 0, 1);
        idle(LEN + 2);

        // Simultaneous strobe and wrap, strobe during DARK
        step(0, 1, 4'd5, 4'd6, 4'd2, 1);
        idle(2);
        step(0, 1, 4'd8, 4'd0, 4'd3, 0);
        idle(LEN);

        // 6. Reset mid-DARK
        step(0, 1, 4'd1, 4'd2, 4'd3, 0);
        step(0, 0, 0, 0, 0, 1);
        idle(2);
        step(1, 0, 0, 0, 0, 0);
        check_val("t6_flash", flashing, 1'b0);
        check_val("t6_hex1", HEX1, 7'b1111111);
        idle(3);

        // Randomized stimulus
        for (int i = 0; i < 3000; i++) begin
            logic       r, d, w;
            logic [3:0] o, t, h;
            r = ($urandom_range(0, 199) == 0);
            d = ($urandom_range(0, 3) == 0);
            w = ($urandom_range(0, 29) == 0);
            o = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
            t = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
            h = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
            step(r, d, o, t, h, w);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/seg_display_driver.md
Name: seg_display_driver

Overview:
- Downstream consumer of the 3-digit BCD seconds counter chain.
- Captures the ones, tens and hundreds BCD digits on a strobe and drives the three 7-segment displays through registered, active-low outputs.
- Performs leading-zero blanking and shows an error glyph for any non-BCD digit.
- A counter-wrap pulse triggers a timed flash of the whole display.

Parameters:
- BLINK_HALF, 25_000_000, length in Clock cycles of each dark and lit flash phase (0.5 s at 50 MHz); must be ≥1.
- BLINK_COUNT, 3, number of dark phases per flash sequence; 0 disables flashing.
- CNT_W, 25, width of the phase counter; must hold BLINK_HALF-1.

Ports:
- Clock  input  1  system clock, CLOCK_50 domain.
- Reset  input  1  synchronous, active-high reset.
- digit_valid  input  1  single-cycle strobe; capture ones/tens/hundreds.
- ones  input  4  BCD units digit.
- tens  input  4  BCD tens digit.
- hundreds  input  4  BCD hundreds digit.
- wrap_pulse  input  1  single-cycle pulse; counter rolled 999→000.
- flashing  output  1  high while the flash sequence is active.
- HEX0  output  [0:6]  right-most display, segments a..g, active-low.
- HEX1  output  [0:6]  middle display.
- HEX2  output  [0:6]  left-most display.

Behaviour:
- Interface timing: single clock (Clock); Reset is synchronous and active-high. All state updates occur on the rising Clock edge.
- Segment encoding, bit 0 = a:
  - 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100
  - 5=0100100, 6=0100000, 7=0001111, 8=0000000, 9=0000100
  - blank=1111111, 'E' (digit >9)=0110000
- Reset (Reset high at an edge):
  - captured digits ← 0, state ← IDLE, phase counter ← 0, dark-phase counter ← 0.
  - flashing ← 0; HEX0/1/2 ← 1111111.
- Capture stage: when digit_valid is high at edge t, the digit register loads all three inputs. With digit_valid low, the digit register holds its value.
- Decode/output stage: registered at every edge from the digit register and the state.
- Latency: the new digits appear on HEX at edge t+1, i.e. 2 edges from strobe sampling to output.
- Leading-zero blanking (see Optional Feature):
  - HEX2 is blank when captured hundreds==0.
  - HEX1 is blank when hundreds==0 and tens==0.
  - HEX0 is never blanked by this rule.
  - An invalid digit counts as nonzero and shows 'E'.
- State machine, states IDLE, DARK, LIT:
  - IDLE: wrap_pulse=1 and BLINK_COUNT>0 → DARK; phase counter ← 0; dark-phase counter ← 1.
  - DARK: phase counter increments each cycle. At BLINK_HALF-1:
    - if dark-phase counter == BLINK_COUNT → IDLE;
    - otherwise → LIT, phase counter ← 0.
  - LIT: phase counter increments each cycle. At BLINK_HALF-1 → DARK; phase counter ← 0; dark-phase counter +1.
- Retrigger: wrap_pulse in DARK or LIT restarts the sequence at DARK with the dark-phase counter ← 1. wrap_pulse takes priority over the phase-end transition in the same cycle.
- Forced blanking: while the state is DARK, the output stage loads blank into all three HEX registers. A state change at edge t is visible on HEX after edge t+1.
- flashing is registered; it equals (state != IDLE) and updates in the same edge as the state.
- Simultaneous digit_valid and wrap_pulse: both are honoured. Digits are captured and displayed normally once the DARK phase ends.
- digit_valid during DARK: captured; not visible until LIT/IDLE.
- Reset mid-flash: immediate return to the reset values above; any pending wrap_pulse is discarded.

Optional Feature:
- Macro: SEG_LEADING_ZERO_BLANK_EN.
- Defined: leading-zero blanking as specified above.
- Undefined: all three digits are always decoded, so 007 shows "007". The 'E' glyph and flash behaviour are unchanged.

Test Plan (bench uses BLINK_HALF=4, BLINK_COUNT=2, macro defined unless noted):
1. Reset high 2 cycles, then low; no strobe → HEX0=0000001, HEX1=HEX2=1111111; flashing=0.
2. digit_valid with hundreds=0, tens=4, ones=9 → two edges later HEX2=1111111, HEX1=1001100, HEX0=0000100.
3. digit_valid with hundreds=1, tens=0, ones=0 → HEX2=1001111, HEX1=HEX0=0000001. With the macro undefined, input 0/0/7 → HEX2=HEX1=0000001, HEX0=0001111.
4. ones=4'hC strobed → HEX0=0110000. Other digits follow the blanking rules.
5. wrap_pulse in IDLE:
   - flashing=1 the next cycle.
   - HEX all 1111111 for 4 cycles, then digits shown for 4 cycles, then blank for 4 cycles.
   - Then IDLE, flashing=0: 12 cycles total.
   - A second wrap_pulse during the LIT phase restarts a full 12-cycle sequence.
6. Reset asserted in the middle of a DARK phase → next edge: flashing=0, HEX=1111111, captured digits 0.
